online_otf_converter: RTL and testbench
=======================================

# online_otf_converter

Digit-serial on-the-fly converter that turns a redundant signed-digit word produced by the online arithmetic datapath (for example, the registered output of the Taylor-log evaluator) into a conventional two's-complement number. It consumes the word MSD-first, one digit per clock, and updates a Q/QM register pair. It sits at the read side of the online datapath, between the evaluator output register and any binary consumer such as a checker, a scoreboard or the FPGA result FIFO.

## Interface
- `Stage`, default 8: number of fractional digits.
- Derived widths:
  - `WL_IN = 2*(Stage+1)`: input word width.
  - `WL_OUT = Stage+2`: output width.
- `clk`  in  1: the single clock; rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `din`  in  WL_IN: redundant word, Stage+1 digits.
  - Digit i occupies bits [2i+1:2i].
  - Digit Stage (bits [WL_IN-1:WL_IN-2]) has weight 2^0.
  - Digit i has weight 2^(i-Stage).
- `in_valid`  in  1: `din` is valid.
- `in_ready`  out  1: converter can accept a word.
- `dout`  out  WL_OUT: two's complement, Q2.Stage format (value × 2^Stage).
- `out_valid`  out  1: `dout` holds a completed result.
- `out_ready`  in  1: consumer accepts `dout`.

## Operation
- Digit encoding {p,n}:
  - 10 = +1.
  - 01 = −1.
  - 00 = 0.
  - 11 = 0 (legal; treated as zero).
- The input range is ±(2−2^-Stage). It always fits WL_OUT, so no overflow is possible.
- FSM states are IDLE, CONV and DONE.
  - IDLE:
    - `in_ready`=1.
    - On `in_valid`, latch `din` into a shift register, set Q=0, QM=all-ones (−1) and cnt=Stage, then go to CONV.
  - CONV:
    - Each cycle, take digit d from the top two bits of the shift register.
    - Shift the register left by 2 and decrement cnt.
    - When a digit is processed with cnt==0, go to DONE.
  - DONE:
    - `out_valid`=1 and `dout`=Q.
    - On `out_ready`, go to IDLE.
- Q/QM update rules (all integer, WL_OUT bits, wrap-free by range):
  - d=+1: Q←2Q+1, QM←2Q.
  - d=0: Q←2Q, QM←2QM+1.
  - d=−1: Q←2QM+1, QM←2QM.
- `dout` is driven directly from the Q register. It is stable and unchanged for the whole of DONE.
- `in_ready` is 0 in CONV and DONE. There is no input skid buffer.
- `in_valid` while `in_ready`=0 is ignored. `din` is sampled only on the accept edge.

## Timing
- Reset values:
  - state=IDLE.
  - `in_ready`=1.
  - `out_valid`=0.
  - `dout`=0.
  - Q=0, QM=−1, cnt=0, shift register=0.
- `rst` overrides everything in any state, including mid-CONV and DONE. The in-flight word is discarded, and no `out_valid` pulse follows.
- Accept: `in_valid`&&`in_ready` at edge E0.
  - Digits are processed at edges E1..E(Stage+1).
  - `out_valid` rises after E(Stage+1).
- Latency: Stage+1 cycles from accept to `out_valid`.
- Throughput: one word per Stage+3 cycles with `out_ready` tied high. The sequence is accept, Stage+1 CONV cycles, one DONE cycle, then IDLE again.
- Backpressure: with `out_ready`=0, DONE holds indefinitely and `dout` stays constant.
- Output handshake: `out_valid`&&`out_ready` at edge Ek gives `out_valid`=0 and `in_ready`=1 after Ek.
- `out_ready` sampled high in IDLE or CONV has no effect.

## Structure
- Shared package `online_pkg`:
  - Digit-encoding constants DIG_POS=2'b10, DIG_NEG=2'b01.
  - Width functions WL_IN(Stage) and WL_OUT(Stage).
  - FSM state encoding.
- One sub-module is natural: `online_otf_step`.
  - Combinational.
  - Inputs: Q, QM, digit.
  - Outputs: next Q, next QM.
- Top level owns the FSM, the counter and the shift register.

## Test plan (Stage=8, WL_IN=18, WL_OUT=10)
- Reset check: hold `rst` for 2 cycles → `in_ready`=1, `out_valid`=0, `dout`=10'h000.
- Zero words:
  - `din`=18'h00000 → `dout`=10'h000 after 9 cycles.
  - `din`=18'h3FFFF (all digits 11) → `dout`=10'h000.
- Positive values:
  - `din`=18'h20000 (MSD=+1) → `dout`=10'h100 (1.0).
  - `din`=18'h24000 (+1, −1) → `dout`=10'h080 (0.5).
- Most-negative word: `din`=18'h15555 (all −1) → `dout`=10'h201 (−511/256).
- Backpressure and back-to-back:
  - Hold `out_ready`=0 for 5 cycles in DONE → `dout` is stable and `in_ready`=0 throughout.
  - Assert `out_ready`, then immediately present 18'h20000 → the next accept occurs in the following cycle and yields 10'h100.
- Reset mid-CONV: assert `rst` at E4 after an accept → IDLE on the next cycle, no `out_valid`, and the next word converts correctly.

Source files
------------

// File: rtl/online_pkg.sv
// Shared definitions for the online arithmetic datapath: signed-digit encoding,
// derived word widths and the converter FSM state encoding.
package online_pkg;

    localparam logic [1:0] DIG_POS  = 2'b10;
    localparam logic [1:0] DIG_NEG  = 2'b01;
    localparam logic [1:0] DIG_ZERO = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } otf_state_e;

    // Redundant word: Stage+1 two-bit digits.
    function automatic int WL_IN(input int stage);
        return 2 * (stage + 1);
    endfunction

    // Two's-complement result in Q2.Stage format.
    function automatic int WL_OUT(input int stage);
        return stage + 2;
    endfunction

endpackage

// File: rtl/online_otf_step.sv
// One on-the-fly conversion step: appends a signed digit to the Q/QM pair,
// where QM always tracks Q minus one unit in the last place.
module online_otf_step
    import online_pkg::*;
#(
    parameter int WL = 10
) (
    input  logic [WL-1:0] q_i,
    input  logic [WL-1:0] qm_i,
    input  logic [1:0]    digit_i,
    output logic [WL-1:0] q_o,
    output logic [WL-1:0] qm_o
);

    logic [WL-1:0] q2_s;
    logic [WL-1:0] qm2_s;

    assign q2_s  = {q_i[WL-2:0], 1'b0};
    assign qm2_s = {qm_i[WL-2:0], 1'b0};

    // Select the next pair; encodings 00 and 11 both mean a zero digit.
    always_comb begin
        q_o  = q2_s;
        qm_o = qm2_s | WL'(1);
        case (digit_i)
            DIG_POS: begin
                q_o  = q2_s | WL'(1);
                qm_o = q2_s;
            end
            DIG_NEG: begin
                q_o  = qm2_s | WL'(1);
                qm_o = qm2_s;
            end
            default: begin
                q_o  = q2_s;
                qm_o = qm2_s | WL'(1);
            end
        endcase
    end

endmodule

// File: rtl/online_otf_converter.sv
// Digit-serial on-the-fly converter: consumes a redundant signed-digit word
// MSD-first, one digit per clock, and presents the two's-complement result.
module online_otf_converter
    import online_pkg::*;
#(
    parameter int Stage = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WL_IN(Stage)-1:0]     din,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WL_OUT(Stage)-1:0]    dout,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int WlIn  = WL_IN(Stage);
    localparam int WlOut = WL_OUT(Stage);
    localparam int CntW  = $clog2(Stage + 1);

    otf_state_e         state_q;
    logic [WlIn-1:0]    sr_q;
    logic [CntW-1:0]    cnt_q;
    logic [WlOut-1:0]   q_q;
    logic [WlOut-1:0]   qm_q;
    logic [WlOut-1:0]   q_d;
    logic [WlOut-1:0]   qm_d;
    logic [1:0]         digit_s;

    assign digit_s = sr_q[WlIn-1 -: 2];
    assign dout    = q_q;

    online_otf_step #(
        .WL (WlOut)
    ) u_step (
        .q_i     (q_q),
        .qm_i    (qm_q),
        .digit_i (digit_s),
        .q_o     (q_d),
        .qm_o    (qm_d)
    );

    // Control FSM with registered handshakes; owns the digit shifter and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sr_q      <= '0;
            cnt_q     <= '0;
            q_q       <= '0;
            qm_q      <= '1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        sr_q     <= din;
                        cnt_q    <= CntW'(Stage);
                        q_q      <= '0;
                        qm_q     <= '1;
                        in_ready <= 1'b0;
                        state_q  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    q_q   <= q_d;
                    qm_q  <= qm_d;
                    sr_q  <= {sr_q[WlIn-3:0], 2'b00};
                    cnt_q <= cnt_q - CntW'(1);
                    // The digit with cnt==0 is the least significant one.
                    if (cnt_q == '0) begin
                        out_valid <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_online_otf_converter.sv
// Self-checking bench: directed and random signed-digit words compared against
// an arithmetic weighted-sum reference.
module tb_online_otf_converter;

    localparam int STAGE = 8;
    localparam int WIN   = 2 * (STAGE + 1);
    localparam int WOUT  = STAGE + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [WIN-1:0]    din = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WOUT-1:0]   dout;
    logic              out_valid;
    logic              out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    online_otf_converter #(.Stage(STAGE)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Value of the word times 2^STAGE: digit i has weight 2^i in that scale.
    function automatic logic [WOUT-1:0] ref_value(input logic [WIN-1:0] w);
        int acc = 0;
        logic [1:0] d;
        for (int i = 0; i <= STAGE; i++) begin
            d = w[2*i +: 2];
            if (d == 2'b10) acc += (1 << i);
            else if (d == 2'b01) acc -= (1 << i);
        end
        return acc[WOUT-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIN-1:0] w);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq("in_ready_wait", {31'd0, in_ready}, 32'd1);
        din = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        din = WIN'($urandom);
        check_eq("accepted", {31'd0, in_ready}, 32'd0);
    endtask

    // Waits for out_valid, checks latency/value, optional backpressure and release.
    task automatic expect_result(input logic [WIN-1:0] w, input int hold, input bit rel);
        int lat = 0;
        logic [WOUT-1:0] exp_v;
        exp_v = ref_value(w);
        while (!out_valid && lat < 40) begin
            out_ready = 1'($urandom);
            tick();
            lat++;
        end
        out_ready = 1'b0;
        check_eq("latency", lat, STAGE + 1);
        check_eq("dout", {22'd0, dout}, {22'd0, exp_v});
        for (int k = 0; k < hold; k++) begin
            tick();
            check_eq("hold_dout", {22'd0, dout}, {22'd0, exp_v});
            check_eq("hold_valid", {30'd0, out_valid, in_ready}, 32'd2);
        end
        if (rel) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check_eq("release", {30'd0, out_valid, in_ready}, 32'd1);
        end
    endtask

    task automatic convert(input logic [WIN-1:0] w, input int hold);
        send(w);
        expect_result(w, hold, 1'b1);
    endtask

    initial begin
        int seen;
        logic [WIN-1:0] w;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_dout", {22'd0, dout}, 32'd0);

        convert(18'h00000, 0);
        convert(18'h3FFFF, 0);
        convert(18'h20000, 0);
        check_eq("one_lit", {22'd0, dout}, 32'h100);
        convert(18'h24000, 0);
        check_eq("half_lit", {22'd0, dout}, 32'h080);
        convert(18'h15555, 0);
        check_eq("mostneg_lit", {22'd0, dout}, 32'h201);

        // Backpressure then back-to-back accept right after release.
        send(18'h24000);
        expect_result(18'h24000, 5, 1'b0);
        out_ready = 1'b1;
        din = 18'h20000;
        in_valid = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("b2b_release", {30'd0, out_valid, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_eq("b2b_accept", {31'd0, in_ready}, 32'd0);
        expect_result(18'h20000, 0, 1'b1);
        check_eq("b2b_lit", {22'd0, dout}, 32'h100);

        // Reset in the middle of a conversion.
        send(18'h2AAAA);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_state", {30'd0, out_valid, in_ready}, 32'd1);
        check_eq("midrst_dout", {22'd0, dout}, 32'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid) seen++;
        end
        check_eq("midrst_no_valid", seen, 0);
        convert(18'h24000, 0);

        for (int r = 0; r < 25; r++) begin
            w = WIN'($urandom);
            convert(w, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
